gsim_mvm: RTL and testbench

Forward matrix-vector multiplier and the checking end of the GSIM solver interface. It consumes the 16-element solution stream that GSIM emits (valid strobe plus 32-bit signed Q16.16 `x`) and produces b' = A·x as a 16-element stream. A is the fixed symmetric 16×16 band matrix with diagonals (-1, 6, -13, 20, -13, 6, -1).
- In-system use: on-chip self-check of solver convergence.
- Bench use: golden-model accelerator.

---
 rtl/gsim_mvm_if.sv | 28 ++
 rtl/gsim_mvm.sv | 153 +++++++++++++++
 tb/tb_gsim_mvm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gsim_mvm_if.sv
// Stream interface for gsim_mvm: solution input, b' output, and status.
// The optional residual ports exist only when GSIM_MVM_RESID_EN is defined.
interface gsim_mvm_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 38
);
  logic             in_en;
  logic [IN_W-1:0]  x_in;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] b_out;
  logic             done;
  logic             busy;
`ifdef GSIM_MVM_RESID_EN
  logic [15:0]      b_ref;
  logic [OUT_W-1:0] resid_max;

  modport master (output in_en, x_in, b_ref,
                  input  in_ready, out_valid, b_out, done, busy, resid_max);
  modport slave  (input  in_en, x_in, b_ref,
                  output in_ready, out_valid, b_out, done, busy, resid_max);
`else
  modport master (output in_en, x_in,
                  input  in_ready, out_valid, b_out, done, busy);
  modport slave  (input  in_en, x_in,
                  output in_ready, out_valid, b_out, done, busy);
`endif
endinterface

// File: rtl/gsim_mvm.sv
// Forward band-matrix multiply b' = A*x (diagonals -1,6,-13,20,-13,6,-1) over a 7-tap window.
// Optional residual tracker enabled by the macro GSIM_MVM_RESID_EN.
module gsim_mvm #(
  parameter int N     = 16,
  parameter int IN_W  = 32,
  parameter int OUT_W = 38
) (
  input  logic       clk,
  input  logic       reset,
  gsim_mvm_if.slave  bus
);

  localparam int ICW = $clog2(N + 1);
  localparam int OCW = $clog2(N);
  localparam logic [ICW-1:0] IN_ONE   = ICW'(1);
  localparam logic [ICW-1:0] IN_FILL  = ICW'(2);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(N - 1);
  localparam logic [OCW-1:0] OUT_ONE  = OCW'(1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(N - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

  state_t                   state_q;
  logic [ICW-1:0]           in_cnt_q;
  logic [OCW-1:0]           out_cnt_q;
  logic signed [IN_W-1:0]   win_q [7];
  logic signed [IN_W-1:0]   win_d [7];
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     done_q;
  logic                     busy_q;
  logic signed [OUT_W-1:0]  b_out_q;
  logic signed [OUT_W-1:0]  b_d;
  logic signed [OUT_W-1:0]  s1, s2, s3, cen;
  logic                     accept;
  logic                     shift;
  logic                     emit;

  function automatic logic signed [OUT_W-1:0] ext(input logic signed [IN_W-1:0] v);
    return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  // Next window and the b' term it yields; FLUSH pushes zeros to pad past x[N-1].
  always_comb begin
    accept = bus.in_en && in_ready_q;
    shift  = accept || (state_q == FLUSH);
    emit   = (accept && (state_q == STREAM)) || (state_q == FLUSH);
    for (int i = 0; i < 6; i++) begin
      win_d[i] = win_q[i+1];
    end
    win_d[6] = (state_q == FLUSH) ? '0 : bus.x_in;
    s1  = ext(win_d[0]) + ext(win_d[6]);
    s2  = ext(win_d[1]) + ext(win_d[5]);
    s3  = ext(win_d[2]) + ext(win_d[4]);
    cen = ext(win_d[3]);
    b_d = (s2 <<< 2) + (s2 <<< 1) - s1
        - ((s3 <<< 3) + (s3 <<< 2) + s3)
        + (cen <<< 4) + (cen <<< 2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      win_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      b_out_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      out_valid_q <= emit;
      if (emit) b_out_q <= b_d;
      if (shift) win_q <= win_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            in_cnt_q <= IN_ONE;
            busy_q   <= 1'b1;
            state_q  <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            in_cnt_q <= in_cnt_q + IN_ONE;
            if (in_cnt_q == IN_FILL) state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            in_cnt_q  <= in_cnt_q + IN_ONE;
            out_cnt_q <= out_cnt_q + OUT_ONE;
            if (in_cnt_q == IN_LAST) begin
              state_q    <= FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        FLUSH: begin
          out_cnt_q <= out_cnt_q + OUT_ONE;
          if (out_cnt_q == OUT_LAST) begin
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.b_out     = b_out_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

`ifdef GSIM_MVM_RESID_EN
  logic                    first_q;
  logic [OUT_W-1:0]        resid_q;
  logic [OUT_W-1:0]        resid_cur;
  logic signed [OUT_W-1:0] ref_ext;
  logic signed [OUT_W-1:0] diff;
  logic [OUT_W-1:0]        abs_diff;

  // Folding the current element in combinationally makes the max final in the done cycle.
  always_comb begin
    ref_ext   = {{(OUT_W-32){bus.b_ref[15]}}, bus.b_ref, 16'b0};
    diff      = ref_ext - b_out_q;
    abs_diff  = diff[OUT_W-1] ? (-diff) : diff;
    resid_cur = resid_q;
    if (out_valid_q && (first_q || (abs_diff > resid_q))) resid_cur = abs_diff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q <= 1'b0;
      resid_q <= '0;
    end else begin
      first_q <= emit && (out_cnt_q == '0);
      resid_q <= resid_cur;
    end
  end

  assign bus.resid_max = resid_cur;
`endif

endmodule

// File: tb/tb_gsim_mvm.sv
// Scoreboard bench for gsim_mvm: expected b' from an independent multiply model,
// checked as outputs appear; covers gaps, back-to-back vectors and mid-vector reset.
module tb_gsim_mvm;

  localparam int N     = 16;
  localparam int IN_W  = 32;
  localparam int OUT_W = 38;

  typedef logic [IN_W-1:0] vec_t [N];

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gsim_mvm_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gsim_mvm #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef GSIM_MVM_RESID_EN
  assign bus.b_ref = '0;
`endif

  int checks  = 0;
  int fails   = 0;
  int outIdx  = 0;
  int outCnt  = 0;
  int doneCnt = 0;
  bit checkEn = 1'b0;
  logic [OUT_W-1:0] expQ [$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] refB(input vec_t xs, input int i);
    int     c [7] = '{-1, 6, -13, 20, -13, 6, -1};
    longint acc = 0;
    for (int d = 0; d < 7; d++) begin
      int j = i + d - 3;
      if (j >= 0 && j < N) acc += longint'(c[d]) * longint'($signed(xs[j]));
    end
    return acc[OUT_W-1:0];
  endfunction

  // Pop and compare each emitted element; done must coincide with the last index.
  always @(negedge clk) begin
    if (!checkEn) begin
      outIdx = 0;
    end else if (reset) begin
      if (bus.out_valid) begin
        logic [OUT_W-1:0] e;
        outCnt++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("b_out[%0d]", outIdx), 64'(bus.b_out), 64'(e));
        end
        checkOutput("done_align", 64'(bus.done), 64'(outIdx == N - 1));
        outIdx = (outIdx == N - 1) ? 0 : outIdx + 1;
      end else if (bus.done) begin
        checkOutput("done_without_valid", 64'd1, 64'd0);
      end
      if (bus.done) doneCnt++;
    end
  end

  task automatic applyStimulus(input vec_t xs, input int gapPct, input int stallK);
    bit accepted;
    int guard;
    for (int i = 0; i < N; i++) expQ.push_back(refB(xs, i));
    for (int k = 0; k < N; k++) begin
      if (k == stallK) begin
        repeat (2) begin
          @(negedge clk);
          bus.in_en = 1'b0;
        end
      end
      accepted = 1'b0;
      guard = 0;
      while (!accepted && guard < 100) begin
        @(negedge clk);
        guard++;
        if (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
          bus.in_en = 1'b0;
        end else begin
          bus.in_en = 1'b1;
          bus.x_in  = xs[k];
          accepted  = bus.in_ready;
        end
      end
      if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
      if (k == 5) checkOutput("busy_mid", 64'(bus.busy), 64'd1);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    bus.in_en = 1'b0;
    for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v, r1, r2;
    int   doneBase, outBase;

    bus.in_en = 1'b0;
    bus.x_in  = '0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_b_out",     64'(bus.b_out),     64'd0);
    checkOutput("rst_done",      64'(bus.done),      64'd0);
    checkOutput("rst_busy",      64'(bus.busy),      64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;

    $display("[TB] impulse at x[0]");
    foreach (v[i]) v[i] = '0;
    v[0] = 32'h0001_0000;
    applyStimulus(v, 0, -1);
    drain();
    checkOutput("done_count_imp0", 64'(doneCnt), 64'd1);

    $display("[TB] impulse at x[8]");
    foreach (v[i]) v[i] = '0;
    v[8] = 32'h0001_0000;
    applyStimulus(v, 0, -1);
    drain();

    $display("[TB] all ones");
    foreach (v[i]) v[i] = 32'h0001_0000;
    applyStimulus(v, 0, -1);
    drain();

    $display("[TB] all most-negative");
    foreach (v[i]) v[i] = 32'h8000_0000;
    applyStimulus(v, 0, -1);
    drain();

    $display("[TB] random vector gapless, then gapped back-to-back pair");
    foreach (r1[i]) r1[i] = $urandom;
    foreach (r2[i]) r2[i] = $urandom;
    applyStimulus(r1, 0, -1);
    drain();
    doneBase = doneCnt;
    outBase  = outCnt;
    applyStimulus(r1, 30, 3);
    applyStimulus(r2, 30, -1);
    drain();
    checkOutput("b2b_gap_outputs", 64'(outCnt - outBase), 64'd32);
    checkOutput("b2b_gap_dones",   64'(doneCnt - doneBase), 64'd2);

    $display("[TB] gapless back-to-back pair");
    doneBase = doneCnt;
    outBase  = outCnt;
    applyStimulus(r2, 0, -1);
    applyStimulus(r1, 0, -1);
    drain();
    checkOutput("b2b_outputs", 64'(outCnt - outBase), 64'd32);
    checkOutput("b2b_dones",   64'(doneCnt - doneBase), 64'd2);

    $display("[TB] reset after x[9]");
    checkEn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.in_en = 1'b1;
      bus.x_in  = r2[k];
    end
    @(negedge clk);
    bus.in_en = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_busy",      64'(bus.busy),      64'd0);
    checkOutput("abort_in_ready",  64'(bus.in_ready),  64'd1);
    @(negedge clk);
    checkOutput("abort_hold_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkEn = 1'b1;
    doneBase = doneCnt;
    applyStimulus(r2, 0, -1);
    drain();
    checkOutput("post_abort_done", 64'(doneCnt - doneBase), 64'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
